// File: rtl/aclk_timegen.sv
// aclk_timegen: time base for the alarm clock.
// A prescaler divides clk down to a one-cycle one_second pulse. A 0..59
// seconds counter turns that into a one_minute pulse, and each one_minute
// pulse advances a 24-hour BCD time (hh:mm). The time can be loaded from
// four BCD digits. Loads that are out of range are rejected with a
// one-cycle load_err pulse.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset (time -> 00:00)
//   reset_count   clears prescaler and seconds, suppresses pulses
//   load_new_c    level-sensitive load of new_* digits (reloads every cycle)
//   fast_watch    one_minute fires on every one_second
//   new_ms_hr, new_ls_hr, new_ms_min, new_ls_min   BCD load digits
//   one_second    one-cycle pulse per second
//   one_minute    one-cycle pulse per minute (per second in fast_watch)
//   ms_hr, ls_hr, ms_min, ls_min   current time, BCD
//   load_err      one-cycle pulse on a rejected load
module aclk_timegen #(
   parameter int CLK_PER_SEC = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       reset_count,
   input  logic       load_new_c,
   input  logic       fast_watch,
   input  logic [3:0] new_ms_hr,
   input  logic [3:0] new_ls_hr,
   input  logic [3:0] new_ms_min,
   input  logic [3:0] new_ls_min,
   output logic       one_second,
   output logic       one_minute,
   output logic [3:0] ms_hr,
   output logic [3:0] ls_hr,
   output logic [3:0] ms_min,
   output logic [3:0] ls_min,
   output logic       load_err
);

   localparam logic [15:0] PRE_MAX = 16'(CLK_PER_SEC - 1);

   logic [15:0] prescale;
   logic [5:0]  seconds;

   logic       tick;
   logic       min_inc;
   logic       hr_ok;
   logic       min_ok;
   logic       load_valid;
   logic [3:0] nxt_ms_hr;
   logic [3:0] nxt_ls_hr;
   logic [3:0] nxt_ms_min;
   logic [3:0] nxt_ls_min;

   // reset_count holds the prescaler at 0, so no tick can happen while it is high
   assign tick    = !reset_count && (prescale == PRE_MAX);
   assign min_inc = tick && ((seconds == 6'd59) || fast_watch);

   // Hours 00..19 allow any ls_hr digit 0..9; hour 2x only allows 20..23
   assign hr_ok      = ((new_ms_hr < 4'd2) && (new_ls_hr <= 4'd9)) ||
                       ((new_ms_hr == 4'd2) && (new_ls_hr <= 4'd3));
   assign min_ok     = (new_ms_min <= 4'd5) && (new_ls_min <= 4'd9);
   assign load_valid = hr_ok && min_ok;

   // BCD increment of hh:mm with carries and 23:59 -> 00:00 wrap
   always_comb begin
      nxt_ms_hr  = ms_hr;
      nxt_ls_hr  = ls_hr;
      nxt_ms_min = ms_min;
      nxt_ls_min = ls_min;
      if (ls_min != 4'd9) begin
         nxt_ls_min = ls_min + 4'd1;
      end else begin
         nxt_ls_min = 4'd0;
         if (ms_min != 4'd5) begin
            nxt_ms_min = ms_min + 4'd1;
         end else begin
            nxt_ms_min = 4'd0;
            if ((ms_hr == 4'd2) && (ls_hr == 4'd3)) begin
               nxt_ms_hr = 4'd0;
               nxt_ls_hr = 4'd0;
            end else if (ls_hr == 4'd9) begin
               nxt_ls_hr = 4'd0;
               nxt_ms_hr = ms_hr + 4'd1;
            end else begin
               nxt_ls_hr = ls_hr + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale   <= '0;
         seconds    <= '0;
         one_second <= 1'b0;
         one_minute <= 1'b0;
         load_err   <= 1'b0;
         ms_hr      <= '0;
         ls_hr      <= '0;
         ms_min     <= '0;
         ls_min     <= '0;
      end else begin
         if (reset_count) begin
            prescale <= '0;
            seconds  <= '0;
         end else if (tick) begin
            prescale <= '0;
            seconds  <= (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
         end else begin
            prescale <= prescale + 16'd1;
         end
         one_second <= tick;
         one_minute <= min_inc;
         load_err   <= load_new_c && !load_valid;

         // Any load request (valid or not) swallows a coincident minute increment
         if (load_new_c) begin
            if (load_valid) begin
               ms_hr  <= new_ms_hr;
               ls_hr  <= new_ls_hr;
               ms_min <= new_ms_min;
               ls_min <= new_ls_min;
            end
         end else if (min_inc) begin
            ms_hr  <= nxt_ms_hr;
            ls_hr  <= nxt_ls_hr;
            ms_min <= nxt_ms_min;
            ls_min <= nxt_ls_min;
         end
      end
   end

endmodule

// File: tb/tb_aclk_timegen.sv
module tb_aclk_timegen;

   localparam int CPS = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       reset_count;
   logic       load_new_c;
   logic       fast_watch;
   logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
   logic       one_second, one_minute, load_err;
   logic [3:0] ms_hr, ls_hr, ms_min, ls_min;

   aclk_timegen #(.CLK_PER_SEC(CPS)) dut (
      .clk(clk), .rst(rst), .reset_count(reset_count), .load_new_c(load_new_c),
      .fast_watch(fast_watch), .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr),
      .new_ms_min(new_ms_min), .new_ls_min(new_ls_min), .one_second(one_second),
      .one_minute(one_minute), .ms_hr(ms_hr), .ls_hr(ls_hr), .ms_min(ms_min),
      .ls_min(ls_min), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: cycle count within the second, second of the minute,
   // and time of day as plain minutes since midnight.
   int m_pre, m_sec, m_tmin;
   bit m_os, m_om, m_le;

   function automatic bit valid_load(int mh, int lh, int mm, int lm);
      return (mh <= 2) && (lh <= 9) && ((mh * 10 + lh) <= 23) && (mm <= 5) && (lm <= 9);
   endfunction

   function automatic logic [15:0] bcd_time(int tmin);
      int h, m;
      h = tmin / 60;
      m = tmin % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   task automatic model_edge();
      bit tick;
      if (rst) begin
         m_pre = 0; m_sec = 0; m_tmin = 0;
         m_os = 0; m_om = 0; m_le = 0;
      end else begin
         tick = !reset_count && (m_pre == CPS - 1);
         m_om = tick && (m_sec == 59 || fast_watch);
         m_os = tick;
         if (reset_count) begin
            m_pre = 0;
            m_sec = 0;
         end else begin
            m_pre = (m_pre + 1) % CPS;
            if (tick) m_sec = (m_sec + 1) % 60;
         end
         m_le = 0;
         if (load_new_c) begin
            if (valid_load(int'(new_ms_hr), int'(new_ls_hr), int'(new_ms_min), int'(new_ls_min)))
               m_tmin = (int'(new_ms_hr) * 10 + int'(new_ls_hr)) * 60
                        + int'(new_ms_min) * 10 + int'(new_ls_min);
            else
               m_le = 1;
         end else if (m_om) begin
            m_tmin = (m_tmin + 1) % 1440;
         end
      end
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] dut_time();
      return {ms_hr, ls_hr, ms_min, ls_min};
   endfunction

   // One clock: model follows the edge, DUT sampled 1 time unit later
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("cycle", {13'd0, one_second, one_minute, load_err, dut_time()},
            {13'd0, m_os, m_om, m_le, bcd_time(m_tmin)});
   endtask

   task automatic set_load(input bit en, input int mh, input int lh, input int mm, input int lm);
      load_new_c = en;
      new_ms_hr  = 4'(mh);
      new_ls_hr  = 4'(lh);
      new_ms_min = 4'(mm);
      new_ls_min = 4'(lm);
   endtask

   int os_count;

   initial begin
      rst = 1'b1; reset_count = 1'b0; fast_watch = 1'b0;
      set_load(0, 0, 0, 0, 0);
      m_pre = 0; m_sec = 0; m_tmin = 0; m_os = 0; m_om = 0; m_le = 0;
      repeat (3) cyc();
      check("reset_state", {13'd0, one_second, one_minute, load_err, dut_time()}, 32'd0);

      // First second after release, then the first minute on the 60th pulse
      rst = 1'b0;
      os_count = 0;
      repeat (3) begin cyc(); if (one_second) os_count++; end
      check("no_early_sec", 32'(one_second), 32'd0);
      cyc(); if (one_second) os_count++;
      check("first_sec", 32'(one_second), 32'd1);
      repeat (235) begin cyc(); if (one_second) os_count++; end
      check("no_early_min", 32'(one_minute), 32'd0);
      cyc(); if (one_second) os_count++;
      check("sec_pulses", 32'(os_count), 32'd60);
      check("first_min", 32'(one_minute), 32'd1);
      check("time_0001", 32'(dut_time()), 32'h0001);

      // 23:59 wraps to 00:00 one minute later (load combined with reset_count)
      reset_count = 1'b1; set_load(1, 2, 3, 5, 9);
      cyc();
      reset_count = 1'b0; set_load(0, 0, 0, 0, 0);
      check("load_2359", 32'(dut_time()), 32'h2359);
      repeat (239) cyc();
      cyc();
      check("wrap_min", 32'(one_minute), 32'd1);
      check("wrap_0000", 32'(dut_time()), 32'h0000);
      check("wrap_no_err", 32'(load_err), 32'd0);

      // fast_watch: 09:59 -> 10:00 on the next one_second
      reset_count = 1'b1; set_load(1, 0, 9, 5, 9);
      cyc();
      reset_count = 1'b0; set_load(0, 0, 0, 0, 0); fast_watch = 1'b1;
      repeat (3) cyc();
      cyc();
      check("fast_sec", 32'(one_second), 32'd1);
      check("fast_min", 32'(one_minute), 32'd1);
      check("fast_1000", 32'(dut_time()), 32'h1000);
      fast_watch = 1'b0;

      // Rejected loads keep the time and pulse load_err
      set_load(1, 1, 2, 3, 4);
      cyc();
      set_load(1, 2, 4, 0, 0);
      cyc();
      check("bad_hr_err", 32'(load_err), 32'd1);
      check("bad_hr_time", 32'(dut_time()), 32'h1234);
      set_load(0, 0, 0, 0, 0);
      cyc();
      check("err_one_cycle", 32'(load_err), 32'd0);
      set_load(1, 0, 5, 6, 0);
      cyc();
      check("bad_min_err", 32'(load_err), 32'd1);
      check("bad_min_time", 32'(dut_time()), 32'h1234);
      set_load(0, 0, 0, 0, 0);

      // reset_count held 10 cycles mid-second
      repeat (2) cyc();
      reset_count = 1'b1;
      repeat (10) begin cyc(); check("hold_no_sec", 32'(one_second), 32'd0); end
      reset_count = 1'b0;
      repeat (3) begin cyc(); check("post_hold_quiet", 32'(one_second), 32'd0); end
      cyc();
      check("post_hold_sec", 32'(one_second), 32'd1);

      // Load beats a same-edge minute increment from 12:00
      reset_count = 1'b1; set_load(1, 1, 2, 0, 0);
      cyc();
      reset_count = 1'b0; set_load(0, 0, 0, 0, 0); fast_watch = 1'b1;
      repeat (3) cyc();
      set_load(1, 0, 7, 1, 5);
      cyc();
      check("prio_min", 32'(one_minute), 32'd1);
      check("prio_0715", 32'(dut_time()), 32'h0715);
      set_load(0, 0, 0, 0, 0); fast_watch = 1'b0;

      // Randomized traffic against the reference model
      repeat (4000) begin
         rst         = ($urandom_range(0, 299) == 0);
         reset_count = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) fast_watch = ~fast_watch;
         if ($urandom_range(0, 24) == 0) begin
            if ($urandom_range(0, 1) == 1)
               set_load(1, $urandom_range(0, 2), $urandom_range(0, 9),
                        $urandom_range(0, 5), $urandom_range(0, 9));
            else
               set_load(1, $urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15), $urandom_range(0, 15));
         end else begin
            set_load(0, 0, 0, 0, 0);
         end
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
